// File: rtl/video_pll_dyn_ctrl.sv
// video_pll_dyn_ctrl: runtime divider selection and reset sequencing for a Gowin
// rPLL built with dynamic IDSEL/FBDSEL/ODSEL. Lock is debounced before the
// video-domain reset is released, and a lock timeout retries the PLL reset.
// Optional feature macro: VIDEO_PLL_LOCK_CNT_EN enables the saturating
// lock-loss counter; without it lock_loss_cnt is tied to zero.
module video_pll_dyn_ctrl #(
  parameter int                     NUM_MODES     = 4,
  parameter int                     MODE_W        = 2,
  parameter logic [NUM_MODES*6-1:0] IDSEL_TBL     = {4{6'h00}},
  parameter logic [NUM_MODES*6-1:0] FBDSEL_TBL    = {4{6'h00}},
  parameter logic [NUM_MODES*6-1:0] ODSEL_TBL     = {4{6'h00}},
  parameter int                     RESET_CYCLES  = 16,
  parameter int                     STABLE_CYCLES = 1024,
  parameter int                     LOCK_TIMEOUT  = 65536,
  parameter int                     MAX_RETRY     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode_sel,
  input  logic              mode_req,
  input  logic              pll_lock,
  output logic              pll_reset,
  output logic [5:0]        pll_idsel,
  output logic [5:0]        pll_fbdsel,
  output logic [5:0]        pll_odsel,
  output logic              video_rst_n,
  output logic [MODE_W-1:0] cur_mode,
  output logic              busy,
  output logic              fail,
  output logic [7:0]        lock_loss_cnt
);

  localparam int RST_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int STB_W   = $clog2(STABLE_CYCLES + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int MODE_LW = MODE_W + 1;

  localparam logic [RST_W-1:0]   RST_LAST   = RST_W'(RESET_CYCLES - 1);
  localparam logic [STB_W-1:0]   STB_LAST   = STB_W'(STABLE_CYCLES - 1);
  localparam logic [STB_W-1:0]   STB_MAX    = STB_W'(STABLE_CYCLES);
  localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMO_W-1:0]   TMO_MAX    = TMO_W'(LOCK_TIMEOUT);
  localparam logic [MODE_LW-1:0] MODE_LIMIT = MODE_LW'(NUM_MODES);
  localparam logic [3:0]         RETRY_MAX  = 4'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_APPLY,
    ST_WAIT_LOCK,
    ST_RUN,
    ST_FAIL
  } state_t;

  state_t            state;
  logic [1:0]        lock_sync;
  logic              lock_s;
  logic              req_ok;
  logic [MODE_W-1:0] target;
  logic [3:0]        retry;
  logic [RST_W-1:0]  rst_cnt;
  logic [STB_W-1:0]  stable_cnt;
  logic [TMO_W-1:0]  timeout_cnt;

  // Pick the 6-bit entry for mode m out of a packed table.
  function automatic logic [5:0] tbl_pick(input logic [NUM_MODES*6-1:0] tbl,
                                          input logic [MODE_W-1:0] m);
    logic [5:0] r;
    r = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (m == MODE_W'(i)) r = tbl[6*i +: 6];
    end
    return r;
  endfunction

  assign lock_s = lock_sync[1];
  assign req_ok = mode_req && ({1'b0, mode_sel} < MODE_LIMIT);

  // Two-flop lock synchroniser, held clear while the PLL is in reset so a stale
  // LOCK from the previous divider setting cannot qualify the new one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         lock_sync <= 2'b00;
    else if (pll_reset) lock_sync <= 2'b00;
    else                lock_sync <= {lock_sync[0], pll_lock};
  end

  // Mode/reset sequencer; a valid request overrides every state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_APPLY;
      target      <= '0;
      retry       <= '0;
      rst_cnt     <= '0;
      stable_cnt  <= '0;
      timeout_cnt <= '0;
      pll_reset   <= 1'b1;
      pll_idsel   <= IDSEL_TBL[5:0];
      pll_fbdsel  <= FBDSEL_TBL[5:0];
      pll_odsel   <= ODSEL_TBL[5:0];
      video_rst_n <= 1'b0;
      cur_mode    <= '0;
      busy        <= 1'b1;
      fail        <= 1'b0;
    end else if (req_ok) begin
      state       <= ST_APPLY;
      target      <= mode_sel;
      retry       <= '0;
      rst_cnt     <= '0;
      stable_cnt  <= '0;
      timeout_cnt <= '0;
      pll_reset   <= 1'b1;
      pll_idsel   <= tbl_pick(IDSEL_TBL, mode_sel);
      pll_fbdsel  <= tbl_pick(FBDSEL_TBL, mode_sel);
      pll_odsel   <= tbl_pick(ODSEL_TBL, mode_sel);
      video_rst_n <= 1'b0;
      cur_mode    <= mode_sel;
      busy        <= 1'b1;
      fail        <= 1'b0;
    end else begin
      case (state)
        ST_APPLY: begin
          if (rst_cnt == RST_LAST) begin
            state       <= ST_WAIT_LOCK;
            pll_reset   <= 1'b0;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (!lock_s)                   stable_cnt  <= '0;
          else if (stable_cnt != STB_MAX) stable_cnt <= stable_cnt + 1'b1;
          if (timeout_cnt != TMO_MAX)    timeout_cnt <= timeout_cnt + 1'b1;
          if (lock_s && stable_cnt == STB_LAST) begin
            state       <= ST_RUN;
            video_rst_n <= 1'b1;
            busy        <= 1'b0;
          end else if (timeout_cnt == TMO_LAST) begin
            pll_reset <= 1'b1;
            if (retry < RETRY_MAX) begin
              state      <= ST_APPLY;
              retry      <= retry + 4'd1;
              rst_cnt    <= '0;
              pll_idsel  <= tbl_pick(IDSEL_TBL, target);
              pll_fbdsel <= tbl_pick(FBDSEL_TBL, target);
              pll_odsel  <= tbl_pick(ODSEL_TBL, target);
              cur_mode   <= target;
            end else begin
              state <= ST_FAIL;
              busy  <= 1'b0;
              fail  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state       <= ST_WAIT_LOCK;
            video_rst_n <= 1'b0;
            busy        <= 1'b1;
            stable_cnt  <= '0;
            timeout_cnt <= '0;
          end
        end
        ST_FAIL: begin
          pll_reset   <= 1'b1;
          video_rst_n <= 1'b0;
        end
        default: state <= ST_APPLY;
      endcase
    end
  end

`ifdef VIDEO_PLL_LOCK_CNT_EN
  logic lock_loss_evt;
  assign lock_loss_evt = (state == ST_RUN) && !lock_s && !req_ok;

  // Count lock losses seen in RUN, saturating at 255; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      lock_loss_cnt <= 8'd0;
    else if (lock_loss_evt && lock_loss_cnt != 8'hFF)
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
  end
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: doc/video_pll_dyn_ctrl.md
Name: video_pll_dyn_ctrl

Overview:
Runtime controller for a Gowin rPLL instantiated with DYN_IDIV_SEL/DYN_FBDIV_SEL/DYN_ODIV_SEL = "true". Selects one of NUM_MODES divider settings from a parameter table and sequences the PLL reset. It qualifies lock with a debounce window, retries on lock timeout, and releases a video-domain reset only while the PLL is stably locked. Runs on the 27 MHz board reference clock and sits between the top-level mode selector and the rPLL wrapper.

Parameters:
NUM_MODES, 4, number of selectable video clock modes (2..16)
MODE_W, 2, width of mode index; must satisfy 2**MODE_W >= NUM_MODES
IDSEL_TBL, {4{6'h00}}, packed NUM_MODES*6 raw IDSEL codes; mode m occupies bits [6m+5:6m]
FBDSEL_TBL, {4{6'h00}}, packed FBDSEL codes, same layout
ODSEL_TBL, {4{6'h00}}, packed ODSEL codes, same layout
RESET_CYCLES, 16, pll_reset pulse length in clk cycles (>=2)
STABLE_CYCLES, 1024, consecutive synced-lock cycles required before release
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before a retry
MAX_RETRY, 3, retries per request before FAIL (0..15)

Ports:
clk  in  1  27 MHz reference clock, also drives rPLL CLKIN
rst_n  in  1  asynchronous active-low reset
mode_sel  in  MODE_W  requested mode index, sampled on mode_req
mode_req  in  1  single-cycle request strobe
pll_lock  in  1  rPLL LOCK, asynchronous to clk
pll_reset  out  1  to rPLL RESET, active high
pll_idsel  out  6  to rPLL IDSEL
pll_fbdsel  out  6  to rPLL FBDSEL
pll_odsel  out  6  to rPLL ODSEL
video_rst_n  out  1  video-domain reset, low until lock is qualified
cur_mode  out  MODE_W  mode currently applied
busy  out  1  high in every state except RUN and FAIL
fail  out  1  high in FAIL
lock_loss_cnt  out  8  saturating lock-loss count (see Optional Feature)

Behaviour:
- Reset values: pll_reset=1, selects = mode 0 table entry, video_rst_n=0, cur_mode=0, busy=1, fail=0, lock_loss_cnt=0. All outputs are registered.
- pll_lock passes through a 2-flop synchroniser (lock_s). Every reference to lock below means lock_s.
- States: APPLY, WAIT_LOCK, RUN, FAIL. The state after reset is APPLY with target mode 0.
- APPLY: load the selects from the target table entry on the entry cycle and hold pll_reset=1 for RESET_CYCLES cycles, then go to WAIT_LOCK with pll_reset=0. The selects are stable for the whole reset pulse.
- WAIT_LOCK: the stable counter increments while lock=1 and clears to 0 when lock=0. The timeout counter increments every cycle.
  - stable counter reaches STABLE_CYCLES -> RUN; video_rst_n goes 1 on the RUN entry edge.
  - timeout reaches LOCK_TIMEOUT with retry<MAX_RETRY -> retry++, go to APPLY with the same mode.
  - timeout reaches LOCK_TIMEOUT with retry==MAX_RETRY -> FAIL.
- RUN: lock=0 for one cycle -> video_rst_n=0 on the next edge, lock-loss event, go to WAIT_LOCK. This path does not re-assert pll_reset and clears the counters but not retry.
- FAIL: pll_reset=1 is held and video_rst_n=0. The block leaves FAIL only on mode_req.
- mode_req in any state: latch mode_sel as the target, clear retry, go to APPLY, and drop video_rst_n the next cycle. This applies even when the mode is unchanged, and a request mid-APPLY restarts the reset pulse.
- mode_sel>=NUM_MODES: the request is ignored and the state is unchanged.
- mode_req coincident with a timeout or a lock-loss: mode_req wins.
- cur_mode updates on APPLY entry.
- Counter widths are clog2 of their limits with no wrap: each counter saturates at its limit.

Optional Feature:
VIDEO_PLL_LOCK_CNT_EN
- Defined: lock_loss_cnt increments on each RUN->WAIT_LOCK lock-loss event, saturates at 255, and clears only on rst_n.
- Undefined: lock_loss_cnt is tied to 8'd0 and no counter logic is generated.

Test Plan:
- Reset release with lock tied 1 (RESET_CYCLES=16, STABLE_CYCLES=32): pll_reset high for 16 cycles after the first clk. video_rst_n rises exactly 16+2+32 cycles later (±1 entry cycle, documented). busy=0 in RUN.
- mode_req with mode_sel=2 in RUN: selects equal the mode-2 table entry, cur_mode=2, video_rst_n=0 the next cycle, and pll_reset pulses 16 cycles.
- Lock never asserts (LOCK_TIMEOUT=100, MAX_RETRY=2): exactly 3 pll_reset pulses, then fail=1 with pll_reset held high. A subsequent mode_req clears fail.
- Lock glitch in WAIT_LOCK (low 1 cycle at stable count 20): stable counter restarts and release is delayed by 21 cycles.
- Lock drops in RUN 3 times: video_rst_n falls each time and re-releases after 32 stable cycles with no pll_reset pulse. lock_loss_cnt=3 with the macro defined, 0 without it.
- mode_sel=5 with NUM_MODES=4: no state change. Separately, mode_req mid-APPLY restarts the full 16-cycle pulse.
